gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
- Round-robin scheduler that shares one GCD datapath/controller pair between N requesters.
- Accepts operand pairs over per-requester valid/ready and loads A then B into the shared engine on consecutive cycles.
- Waits for engine done, then returns the result tagged with the requester index.
- Handles zero operands without the engine. A watchdog guards against a hung engine.

Parameters:
- N, 4, number of requesters (2..8).
- W, 16, operand/result width.
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= N.
- TIMEOUT, 1023, maximum WAIT cycles before error abort (W-independent, >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  requester i has an operand pair pending.
- req_a  in  N*W  operand A, requester i at bits [i*W +: W].
- req_b  in  N*W  operand B, same packing.
- req_ready  out  N  one-hot accept pulse; request i consumed when req_valid[i] && req_ready[i].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester served.
- rsp_data  out  W  GCD result.
- rsp_err  out  1  engine timed out; rsp_data = 0.
- eng_start  out  1  start level to the shared GCD controller.
- eng_data_in  out  W  operand bus to the GCD datapath.
- eng_done  in  1  GCD controller done level.
- eng_result  in  W  GCD datapath A register output.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0) values:
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, eng_start=0, eng_data_in=0, busy=0.
  - Internal: state=IDLE, rr pointer=0, watchdog=0.
  - Reset mid-operation discards the in-flight request; no response is produced.
- FSM states: IDLE, GRANT, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - If any req_valid, go to GRANT.
  - Selection is combinational from the rr pointer: the first valid index at or after the pointer, modulo N.
- GRANT (1 cycle):
  - req_ready[g]=1 for the chosen g only; latch a, b, g; rr pointer <= (g+1) mod N.
  - If a==0 or b==0: rsp_data <= a|b, go to RESP. The engine is bypassed and eng_start stays 0. gcd(0,0)=0, rsp_err=0.
  - Otherwise go to LOAD_A.
- LOAD_A (1 cycle): eng_start=1, eng_data_in=a.
- LOAD_B (1 cycle): eng_start=1, eng_data_in=b.
- WAIT:
  - eng_start=1; eng_data_in holds b; watchdog increments every cycle.
  - On eng_done=1: capture eng_result into rsp_data, rsp_err=0, go to RESP.
  - If watchdog reaches TIMEOUT first: rsp_data=0, rsp_err=1, go to RESP.
  - eng_done sampled high in the same cycle the watchdog hits TIMEOUT: the result wins and rsp_err=0.
  - eng_done sampled in LOAD_A or LOAD_B is ignored.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err stable until rsp_valid && rsp_ready.
  - eng_start=0, which returns the engine controller to its idle state.
  - On handshake: clear the watchdog. Go to GRANT if any req_valid (back-to-back), else IDLE.
  - No grant while a response is pending.
- Latency:
  - Engine path: grant cycle to rsp_valid = 3 + E cycles, where E = WAIT cycles until eng_done.
  - Zero bypass: rsp_valid on the cycle after the grant.
- Fairness: each requester is served at most once per N grants while others are pending.
- req_valid dropping before grant is permitted; arbitration uses current-cycle req_valid.
- All outputs are registered except req_ready, which is decoded from state and grant.

Decomposition:
- gcd_pkg holds:
  - state encoding enum (IDLE..RESP);
  - default W, N, IDW, TIMEOUT constants;
  - a function clog2.
- One sub-module, rr_arbiter: N-bit request vector plus pointer in, one-hot grant and index out, purely combinational.
- Pointer update stays in gcd_arbiter.

Test Plan:
- Single request: requester 0 sends (143,78); engine model asserts done after 12 cycles -> rsp_id=0, rsp_data=13, rsp_err=0, eng_data_in=143 then 78 on consecutive cycles.
- Round-robin: all 4 requesters valid continuously with distinct pairs (e.g. (48,18), (35,21), (100,75), (17,5)) -> rsp_id sequence 0,1,2,3,0, rsp_data 6,7,25,1.
- Zero bypass: requester 2 sends (0,25) -> rsp_data=25 one cycle after grant, eng_start never asserted; (0,0) -> rsp_data=0, rsp_err=0.
- Timeout: eng_done held 0 -> rsp_valid with rsp_err=1, rsp_data=0 exactly TIMEOUT WAIT cycles after LOAD_B. The next request then completes normally.
- Backpressure: rsp_ready low for 5 cycles with requester 1 pending -> rsp fields stable, req_ready stays 0. Grant to 1 occurs on the cycle after the handshake.
- Reset mid-WAIT: assert rst_n=0 asynchronously -> all outputs 0 immediately, no response emitted. After release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the round-robin GCD scheduler.
package gcd_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_W       = 16;
  localparam int DEF_IDW     = 2;
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_WAIT,
    ST_RESP
  } gcd_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr) + off) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IDW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD engine among N requesters: round-robin grant, operand load,
// done/watchdog wait, tagged response with zero-operand bypass.
module gcd_arbiter import gcd_pkg::*; #(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int IDW     = DEF_IDW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           eng_start,
  output logic [W-1:0]   eng_data_in,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_result,
  output logic           busy
);

  localparam int WD_W = clog2(TIMEOUT + 1);

  gcd_state_e     state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [WD_W-1:0] wd;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic [W-1:0]   sel_a, sel_b, b_q;
  logic           sel_zero, wd_hit, rsp_hs;

  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign sel_a     = req_a[int'(gnt_idx)*W +: W];
  assign sel_b     = req_b[int'(gnt_idx)*W +: W];
  assign sel_zero  = (sel_a == '0) || (sel_b == '0);
  assign wd_hit    = (wd == WD_W'(TIMEOUT - 1));
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign req_ready = (state == ST_GRANT) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (|req_valid) state_nx = ST_GRANT;
      ST_GRANT: begin
        if (!gnt_any)     state_nx = ST_IDLE;
        else if (sel_zero) state_nx = ST_RESP;
        else               state_nx = ST_LOAD_A;
      end
      ST_LOAD_A: state_nx = ST_LOAD_B;
      // eng_done is deliberately not looked at until the engine has both operands
      ST_LOAD_B: state_nx = ST_WAIT;
      ST_WAIT:   if (eng_done || wd_hit) state_nx = ST_RESP;
      ST_RESP:   if (rsp_hs) state_nx = (|req_valid) ? ST_GRANT : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      wd          <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      eng_start   <= 1'b0;
      eng_data_in <= '0;
      busy        <= 1'b0;
    end else begin
      rsp_valid <= (state_nx == ST_RESP);
      eng_start <= (state_nx == ST_LOAD_A) || (state_nx == ST_LOAD_B) || (state_nx == ST_WAIT);
      busy      <= (state_nx != ST_IDLE);
      case (state)
        ST_GRANT: begin
          if (gnt_any) begin
            rr_ptr <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            rsp_id <= gnt_idx;
            if (sel_zero) begin
              rsp_data <= sel_a | sel_b;
              rsp_err  <= 1'b0;
            end else begin
              eng_data_in <= sel_a;
            end
          end
        end
        ST_LOAD_A: eng_data_in <= b_q;
        ST_WAIT: begin
          wd <= wd + 1'b1;
          // A done arriving on the watchdog's last cycle still counts as success
          if (eng_done) begin
            rsp_data <= eng_result;
            rsp_err  <= 1'b0;
          end else if (wd_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        ST_RESP: if (rsp_hs) wd <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_GRANT) b_q <= sel_b;
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural GCD engine responder.
module tb_gcd_arbiter;

  localparam int N       = 4;
  localparam int W       = 16;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 1023;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           eng_start;
  logic [W-1:0]   eng_data_in;
  logic           eng_done = 1'b0;
  logic [W-1:0]   eng_result = '0;
  logic           busy;

  int total = 0;
  int bad   = 0;

  int eng_delay  = 12;
  int start_seen = 0;
  int k = 0;
  logic [W-1:0] ma = '0, mb = '0;

  gcd_arbiter #(.N(N), .W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_data_in(eng_data_in),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] euclid(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine: first start cycle carries A, second carries B, done after eng_delay WAIT cycles (0 = hang).
  always @(negedge clk) begin
    if (!eng_start) begin
      k = 0;
      eng_done = 1'b0;
    end else begin
      k++;
      start_seen++;
      if (k == 1) ma = eng_data_in;
      else if (k == 2) mb = eng_data_in;
      else if (eng_delay != 0 && k - 2 == eng_delay) begin
        eng_done = 1'b1;
        eng_result = euclid(ma, mb);
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int i, output int ok);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1;
        break;
      end
    end
    if (ok == 1) begin
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int n);
    n = -1;
    for (int c = 1; c < 2000; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_data_in, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0",
               {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_data_in, busy});
    end
    do_reset();
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b rsp_valid=%b required 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_single();
    int ok, n;
    do_reset();
    eng_delay = 12;
    set_req(0, 16'd143, 16'd78);
    wait_grant(0, ok);
    total++;
    if (ok !== 1) begin bad++; $display("FAIL single_grant got=%0d required=1", ok); end
    @(negedge clk);
    total++;
    if (eng_start !== 1'b1 || eng_data_in !== 16'd143) begin
      bad++; $display("FAIL single_load_a start=%b data=%0d required 1/143", eng_start, eng_data_in);
    end
    @(negedge clk);
    total++;
    if (eng_start !== 1'b1 || eng_data_in !== 16'd78) begin
      bad++; $display("FAIL single_load_b start=%b data=%0d required 1/78", eng_start, eng_data_in);
    end
    wait_rsp(n);
    total++;
    if (n + 2 !== 15) begin bad++; $display("FAIL single_latency got=%0d required=15", n + 2); end
    total++;
    if (rsp_id !== 2'd0 || rsp_data !== 16'd13 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL single_rsp id=%0d data=%0d err=%b required 0/13/0", rsp_id, rsp_data, rsp_err);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_after rsp_valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_dat[5] = '{6, 7, 25, 1, 6};
    int ids[5]     = '{-1, -1, -1, -1, -1};
    int dat[5]     = '{-1, -1, -1, -1, -1};
    int got;
    do_reset();
    eng_delay = 3;
    set_req(0, 16'd48, 16'd18);
    set_req(1, 16'd35, 16'd21);
    set_req(2, 16'd100, 16'd75);
    set_req(3, 16'd17, 16'd5);
    got = 0;
    for (int c = 0; c < 400 && got < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids[got] = int'(rsp_id);
        dat[got] = int'(rsp_data);
        got++;
      end
    end
    req_valid = '0;
    total++;
    if (got !== 5) begin bad++; $display("FAIL rr_count got=%0d required=5", got); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ids[i] !== exp_id[i] || dat[i] !== exp_dat[i]) begin
        bad++;
        $display("FAIL rr_rsp%0d id=%0d data=%0d required %0d/%0d", i, ids[i], dat[i], exp_id[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_zero_bypass();
    int ok;
    do_reset();
    start_seen = 0;
    set_req(2, 16'd0, 16'd25);
    wait_grant(2, ok);
    @(negedge clk);
    total++;
    if (ok !== 1 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'd25 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL zero_a ok=%0d valid=%b id=%0d data=%0d err=%b required 1/1/2/25/0",
               ok, rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    set_req(2, 16'd0, 16'd0);
    wait_grant(2, ok);
    @(negedge clk);
    total++;
    if (ok !== 1 || rsp_valid !== 1'b1 || rsp_data !== 16'd0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL zero_both ok=%0d valid=%b data=%0d err=%b required 1/1/0/0", ok, rsp_valid, rsp_data, rsp_err);
    end
    total++;
    if (start_seen !== 0) begin bad++; $display("FAIL zero_no_start got=%0d required=0", start_seen); end
  endtask

  task automatic test_timeout();
    int ok, n;
    do_reset();
    eng_delay = 0;
    set_req(1, 16'd48, 16'd18);
    wait_grant(1, ok);
    wait_rsp(n);
    total++;
    if (n !== 3 + TIMEOUT) begin bad++; $display("FAIL timeout_latency got=%0d required=%0d", n, 3 + TIMEOUT); end
    total++;
    if (rsp_err !== 1'b1 || rsp_data !== 16'd0 || rsp_id !== 2'd1) begin
      bad++; $display("FAIL timeout_rsp err=%b data=%0d id=%0d required 1/0/1", rsp_err, rsp_data, rsp_id);
    end
    eng_delay = 4;
    set_req(3, 16'd35, 16'd21);
    wait_grant(3, ok);
    wait_rsp(n);
    total++;
    if (n !== 7 || rsp_err !== 1'b0 || rsp_data !== 16'd7 || rsp_id !== 2'd3) begin
      bad++;
      $display("FAIL timeout_recover lat=%0d err=%b data=%0d id=%0d required 7/0/7/3", n, rsp_err, rsp_data, rsp_id);
    end
  endtask

  task automatic test_backpressure();
    int ok, n;
    do_reset();
    eng_delay = 2;
    rsp_ready = 1'b0;
    set_req(0, 16'd100, 16'd75);
    wait_grant(0, ok);
    wait_rsp(n);
    set_req(1, 16'd17, 16'd5);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd25 || rsp_err !== 1'b0 || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold%0d valid=%b id=%0d data=%0d err=%b rdy=%b required 1/0/25/0/0000",
                 c, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_next_grant rdy=%b valid=%b required 0010/0", req_ready, rsp_valid);
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(n);
    total++;
    if (n < 0 || rsp_id !== 2'd1 || rsp_data !== 16'd1) begin
      bad++; $display("FAIL bp_second lat=%0d id=%0d data=%0d required id 1 data 1", n, rsp_id, rsp_data);
    end
  endtask

  task automatic test_reset_mid_wait();
    int ok, seen;
    logic [N-1:0] g;
    do_reset();
    eng_delay = 0;
    set_req(2, 16'd100, 16'd75);
    wait_grant(2, ok);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    set_req(1, 16'd48, 16'd18);
    set_req(3, 16'd35, 16'd21);
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_data_in, busy} !== '0) begin
      bad++;
      $display("FAIL midwait_reset got=%h required=0",
               {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_data_in, busy});
    end
    eng_delay = 2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    g = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      if (|req_ready) begin
        g = req_ready;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    total++;
    if (g !== 4'b0010 || seen !== 0) begin
      bad++; $display("FAIL midwait_first_grant gnt=%b stray_rsp=%0d required 0010/0", g, seen);
    end
    wait_rsp(ok);
    total++;
    if (ok < 0 || rsp_id !== 2'd1 || rsp_data !== 16'd6 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL midwait_rsp lat=%0d id=%0d data=%0d err=%b required id 1 data 6 err 0",
                      ok, rsp_id, rsp_data, rsp_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_bypass();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
